// File: rtl/wavetbl_pkg.sv
// Shared definitions for the wavetable player: playback modes, FSM state codes
// and the lane offset helper used to slice packed multi-channel words.
package wavetbl_pkg;

  localparam logic [1:0] WT_ONESHOT  = 2'd0;
  localparam logic [1:0] WT_LOOP     = 2'd1;
  localparam logic [1:0] WT_PINGPONG = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Bit offset of a lane inside a packed word; lane i lives at [i*width +: width].
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/wavetbl_ram.sv
// Multi-lane sample table: per-lane masked synchronous write, asynchronous
// read, and an asynchronous clear of every entry on reset.
module wavetbl_ram
  import wavetbl_pkg::*;
#(
  parameter int CH = 2,
  parameter int A  = 4,
  parameter int D  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [A-1:0]    wr_addr,
  input  logic [CH-1:0]   wr_mask,
  input  logic [CH*D-1:0] wr_data,
  input  logic [A-1:0]    rd_addr,
  output logic [CH*D-1:0] rd_data
);

  localparam int DEPTH = 2 ** A;

  logic [CH*D-1:0] mem_q [DEPTH];
  logic [CH*D-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int c = 0; c < CH; c++) begin
        if (wr_mask[c]) begin
          mem_d[wr_addr][lane_lo(c, D) +: D] = wr_data[lane_lo(c, D) +: D];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write is read-before-write.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/wavetbl_player.sv
// Wavetable playback engine: replays the sample table in one-shot, loop or
// ping-pong order at a programmable rate over a valid/ready output.
module wavetbl_player
  import wavetbl_pkg::*;
#(
  parameter int CH = 2,
  parameter int A  = 4,
  parameter int D  = 16,
  parameter int R  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [A-1:0]    wr_addr,
  input  logic [CH-1:0]   wr_mask,
  input  logic [CH*D-1:0] wr_data,
  input  logic            start,
  input  logic            stop,
  input  logic [1:0]      mode,
  input  logic [A-1:0]    len,
  input  logic [R-1:0]    rate,
  output logic            busy,
  output logic            done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*D-1:0] out_data,
  output logic [A-1:0]    out_addr
);

  logic [1:0]      state_q, state_d;
  logic [A-1:0]    idx_q, idx_d;
  logic            dir_q, dir_d;
  logic [R-1:0]    div_q, div_d;
  logic [1:0]      mode_q, mode_d;
  logic [A-1:0]    len_q, len_d;
  logic [R-1:0]    rate_q, rate_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            done_pend_q, done_pend_d;
  logic            out_valid_q, out_valid_d;
  logic [CH*D-1:0] out_data_q, out_data_d;
  logic [A-1:0]    out_addr_q, out_addr_d;

  logic            start_ok, accept, do_emit;
  logic [1:0]      cur_mode;
  logic [A-1:0]    cur_len, cur_idx;
  logic            cur_dir;
  logic [CH*D-1:0] rd_data;

  wavetbl_ram #(.CH(CH), .A(A), .D(D)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_mask (wr_mask),
    .wr_data (wr_data),
    .rd_addr (cur_idx),
    .rd_data (rd_data)
  );

  // An accepted start emits index 0 on the same edge, using the fresh settings.
  assign start_ok = (state_q == ST_IDLE) && start && !stop;
  assign accept   = out_valid_q && out_ready;
  assign cur_mode = start_ok ? mode : mode_q;
  assign cur_len  = start_ok ? len : len_q;
  assign cur_idx  = start_ok ? '0 : idx_q;
  assign cur_dir  = start_ok ? 1'b0 : dir_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dir_d       = dir_q;
    div_d       = div_q;
    mode_d      = mode_q;
    len_d       = len_q;
    rate_d      = rate_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    done_pend_d = done_pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    do_emit     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          mode_d      = mode;
          len_d       = len;
          rate_d      = rate;
          busy_d      = 1'b1;
          done_pend_d = 1'b0;
          state_d     = ST_RUN;
          do_emit     = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d     = ST_FLUSH;
          done_pend_d = 1'b0;
          if (accept) out_valid_d = 1'b0;
        end else if (div_q == '0 && (!out_valid_q || out_ready)) begin
          do_emit = 1'b1;
        end else begin
          if (div_q != '0) div_d = div_q - 1'b1;
          if (accept) out_valid_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = done_pend_q;
          done_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_emit) begin
      out_data_d  = rd_data;
      out_addr_d  = cur_idx;
      out_valid_d = 1'b1;
      div_d       = start_ok ? rate : rate_q;
      dir_d       = cur_dir;
      idx_d       = cur_idx;
      case (cur_mode)
        WT_ONESHOT: begin
          if (cur_idx == cur_len) begin
            state_d     = ST_FLUSH;
            done_pend_d = 1'b1;
          end else begin
            idx_d = cur_idx + 1'b1;
          end
        end
        // Turn around one step inside each endpoint so no endpoint repeats.
        WT_PINGPONG: begin
          if (!cur_dir) begin
            if (cur_idx == cur_len) begin
              if (cur_len != '0) begin
                idx_d = cur_len - 1'b1;
                dir_d = 1'b1;
              end
            end else begin
              idx_d = cur_idx + 1'b1;
            end
          end else begin
            if (cur_idx == '0) begin
              idx_d = (cur_len == '0) ? '0 : {{(A-1){1'b0}}, 1'b1};
              dir_d = 1'b0;
            end else begin
              idx_d = cur_idx - 1'b1;
            end
          end
        end
        default: idx_d = (cur_idx == cur_len) ? '0 : cur_idx + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      dir_q       <= 1'b0;
      div_q       <= '0;
      mode_q      <= WT_ONESHOT;
      len_q       <= '0;
      rate_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dir_q       <= dir_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      rate_q      <= rate_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_pend_q <= done_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_wavetbl_player.sv
// Directed bench for wavetbl_player: every expected value below is worked out
// by hand from the intended playback behaviour.
module tb_wavetbl_player;

  localparam int CH = 2;
  localparam int A  = 4;
  localparam int D  = 16;
  localparam int R  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en;
  logic [A-1:0]    wr_addr;
  logic [CH-1:0]   wr_mask;
  logic [CH*D-1:0] wr_data;
  logic            start, stop;
  logic [1:0]      mode;
  logic [A-1:0]    len;
  logic [R-1:0]    rate;
  logic            busy, done, out_valid, out_ready;
  logic [CH*D-1:0] out_data;
  logic [A-1:0]    out_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_tab [4];
  int          exp_addr [8];

  always #5 clk = ~clk;

  wavetbl_player #(.CH(CH), .A(A), .D(D), .R(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_mask   (wr_mask),
    .wr_data   (wr_data),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .len       (len),
    .rate      (rate),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives control inputs for one clock, then drops the start/stop pulses.
  task automatic applyStimulus(input logic s, input logic p, input logic [1:0] m,
                               input logic [A-1:0] l, input logic [R-1:0] r);
    start = s;
    stop  = p;
    mode  = m;
    len   = l;
    rate  = r;
    step();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic writeEntry(input logic [A-1:0] a, input logic [CH-1:0] m,
                            input logic [CH*D-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_mask = m;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    exp_tab = '{32'h0000_1000, 32'h1000_0000, 32'h1000_1000, 32'h0000_2000};
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; mode = '0; len = '0; rate = '0; out_ready = 1'b1;

    step();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_data", out_data, 0);
    checkOutput("rst_addr", out_addr, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) writeEntry(i[A-1:0], 2'b11, exp_tab[i]);

    // One-shot over four entries at full rate, then a single done pulse.
    applyStimulus(1'b1, 1'b0, 2'd0, 4'd3, 8'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checkOutput($sformatf("os_valid%0d", i), out_valid, 1);
      checkOutput($sformatf("os_addr%0d", i), out_addr, i);
      checkOutput($sformatf("os_data%0d", i), out_data, exp_tab[i]);
      checkOutput($sformatf("os_done%0d", i), done, 0);
      checkOutput($sformatf("os_busy%0d", i), busy, 1);
    end
    step();
    checkOutput("os_done_pulse", done, 1);
    checkOutput("os_busy_fall", busy, 0);
    checkOutput("os_valid_fall", out_valid, 0);
    step();
    checkOutput("os_done_once", done, 0);

    // Loop with rate 2: each emission is three cycles after the previous one.
    exp_addr = '{0, 1, 2, 0, 1, 0, 0, 0};
    applyStimulus(1'b1, 1'b0, 2'd1, 4'd2, 8'd2);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        for (int j = 0; j < 2; j++) begin
          step();
          checkOutput($sformatf("loop_gap%0d_%0d", k, j), out_valid, 0);
        end
        step();
      end
      checkOutput($sformatf("loop_valid%0d", k), out_valid, 1);
      checkOutput($sformatf("loop_addr%0d", k), out_addr, exp_addr[k]);
      checkOutput($sformatf("loop_done%0d", k), done, 0);
    end
    step();
    applyStimulus(1'b0, 1'b1, 2'd1, 4'd2, 8'd2);
    step();
    checkOutput("loop_stop_busy", busy, 0);
    checkOutput("loop_stop_done", done, 0);

    // Ping-pong bounces between 0 and 3 without repeating endpoints.
    exp_addr = '{0, 1, 2, 3, 2, 1, 0, 1};
    applyStimulus(1'b1, 1'b0, 2'd2, 4'd3, 8'd0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      checkOutput($sformatf("pp_addr%0d", k), out_addr, exp_addr[k]);
      checkOutput($sformatf("pp_data%0d", k), out_data, exp_tab[exp_addr[k]]);
    end
    applyStimulus(1'b0, 1'b1, 2'd2, 4'd3, 8'd0);
    step();
    checkOutput("pp_stop_busy", busy, 0);

    applyStimulus(1'b1, 1'b0, 2'd2, 4'd0, 8'd0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      checkOutput($sformatf("pp0_valid%0d", k), out_valid, 1);
      checkOutput($sformatf("pp0_addr%0d", k), out_addr, 0);
    end
    applyStimulus(1'b0, 1'b1, 2'd2, 4'd0, 8'd0);
    step();
    checkOutput("pp0_stop_busy", busy, 0);

    // Backpressure holds the sample; stop during a stall keeps it pending.
    applyStimulus(1'b1, 1'b0, 2'd1, 4'd3, 8'd0);
    checkOutput("bp_addr0", out_addr, 0);
    step();
    checkOutput("bp_addr1", out_addr, 1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput($sformatf("bp_hold_valid%0d", k), out_valid, 1);
      checkOutput($sformatf("bp_hold_addr%0d", k), out_addr, 1);
      checkOutput($sformatf("bp_hold_data%0d", k), out_data, exp_tab[1]);
    end
    out_ready = 1'b1;
    step();
    checkOutput("bp_next_addr", out_addr, 2);
    step();
    checkOutput("bp_next_addr2", out_addr, 3);
    out_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 2'd1, 4'd3, 8'd0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      checkOutput($sformatf("stall_stop_valid%0d", k), out_valid, 1);
      checkOutput($sformatf("stall_stop_addr%0d", k), out_addr, 3);
      checkOutput($sformatf("stall_stop_busy%0d", k), busy, 1);
    end
    out_ready = 1'b1;
    step();
    checkOutput("stall_stop_idle_valid", out_valid, 0);
    checkOutput("stall_stop_idle_busy", busy, 0);
    checkOutput("stall_stop_idle_done", done, 0);

    applyStimulus(1'b1, 1'b1, 2'd0, 4'd3, 8'd0);
    checkOutput("startstop_busy", busy, 0);
    checkOutput("startstop_valid", out_valid, 0);
    step();
    checkOutput("startstop_busy2", busy, 0);

    // Lane-0 write to the entry being emitted: old data now, new data next pass.
    applyStimulus(1'b1, 1'b0, 2'd1, 4'd1, 8'd0);
    checkOutput("mw_data0", out_data, 32'h0000_1000);
    writeEntry(4'd1, 2'b01, 32'hFFFF_ABCD);
    checkOutput("mw_old_addr", out_addr, 1);
    checkOutput("mw_old_data", out_data, 32'h1000_0000);
    step();
    checkOutput("mw_wrap_data", out_data, 32'h0000_1000);
    step();
    checkOutput("mw_new_addr", out_addr, 1);
    checkOutput("mw_new_data", out_data, 32'h1000_ABCD);
    applyStimulus(1'b0, 1'b1, 2'd1, 4'd1, 8'd0);
    step();
    checkOutput("mw_stop_busy", busy, 0);

    // Asynchronous reset in the middle of a run, sampled between clock edges.
    applyStimulus(1'b1, 1'b0, 2'd1, 4'd3, 8'd0);
    step();
    checkOutput("ar_pre_valid", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", out_valid, 0);
    checkOutput("ar_busy", busy, 0);
    checkOutput("ar_done", done, 0);
    checkOutput("ar_data", out_data, 0);
    checkOutput("ar_addr", out_addr, 0);
    step();
    rst_n = 1'b1;
    step();
    applyStimulus(1'b1, 1'b0, 2'd0, 4'd3, 8'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checkOutput($sformatf("ar_tab_addr%0d", i), out_addr, i);
      checkOutput($sformatf("ar_tab_data%0d", i), out_data, 0);
    end
    step();
    checkOutput("ar_tab_done", done, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wavetbl_player.md
Name: wavetbl_player

Overview:
- Multi-channel wavetable playback engine and the next generation of the fixed two-signal wave table.
- Holds a writable table of 2^A entries per channel and replays it as a sample stream.
- Playback rate and last index are programmable; modes are one-shot, loop and ping-pong.
- Samples go to the downstream DSP/DAC path over a valid/ready handshake.

Parameters:
- CH, 2, number of channels, >= 1.
- A, 4, table address width; depth is 2^A.
- D, 16, sample width per channel.
- R, 8, rate divider width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  A  table write index.
- wr_mask  in  CH  per-channel write enable; bit i selects lane i.
- wr_data  in  CH*D  write data; lane i is bits [i*D +: D].
- start  in  1  start playback; ignored while busy.
- stop  in  1  abort playback.
- mode  in  2  0 one-shot, 1 loop, 2 ping-pong, 3 treated as loop.
- len  in  A  last table index played.
- rate  in  R  idle cycles between emissions; spacing is rate+1.
- busy  out  1  high from start until return to IDLE.
- done  out  1  one-cycle pulse when one-shot completes.
- out_valid  out  1  sample valid.
- out_ready  in  1  downstream accept.
- out_data  out  CH*D  sample for all channels, same lane packing as wr_data.
- out_addr  out  A  table index of the current sample.

Behaviour:
- Reset (async, rst_n=0):
  - All table entries are 0.
  - Outputs: busy=0, done=0, out_valid=0, out_data=0, out_addr=0.
  - Internal: state=IDLE, index=0, direction=up, divider=0.
  - Recovery is synchronous on the first clk edge after rst_n rises.
- Table:
  - Synchronous masked write on wr_en.
  - Asynchronous read at the playback index.
  - A write to the index being emitted in the same cycle yields the old data (read-before-write).
  - Writes are allowed in any state.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - If start=1 and stop=0: latch mode/len/rate, index=0, direction=up, divider=0, busy=1, go to RUN.
  - start together with stop: stop wins; remain IDLE.
- RUN:
  - Emit condition: divider==0 and (out_valid==0 or out_ready==1).
  - On emit: out_data=table[index], out_addr=index, out_valid=1, divider=rate, index advances.
  - Otherwise: divider decrements, saturating at 0. If out_valid and out_ready, out_valid=0.
  - First sample is valid on the cycle after start.
  - With out_ready held high, samples are spaced rate+1 cycles.
- Handshake:
  - While out_valid=1 and out_ready=0, out_data and out_addr are held stable.
  - No sample is ever dropped or duplicated by a stall.
- Index advance after emitting index i:
  - Loop: i==len -> 0; otherwise i+1.
  - Ping-pong, direction up: i==len -> len-1 and direction=down. When len==0, index stays 0.
  - Ping-pong, direction down: i==0 -> 1 and direction=up. Endpoints are never emitted twice in a row.
  - One-shot: after emitting len, go to FLUSH.
- FLUSH:
  - No new emissions.
  - When out_valid==0, or out_valid and out_ready: out_valid=0, busy=0, go to IDLE.
  - done=1 for exactly that one cycle, only if entry was a one-shot completion.
- stop in RUN:
  - Go to FLUSH with done suppressed.
  - A pending sample is still held until it is accepted.
- start while busy: ignored.
- mode/len/rate input changes while busy: no effect until the next start.

Decomposition:
- Shared package wavetbl_pkg holds:
  - Mode constants WT_ONESHOT=0, WT_LOOP=1, WT_PINGPONG=2.
  - State encoding for IDLE/RUN/FLUSH.
  - Lane-slice helper function.
- One sub-module, wavetbl_ram:
  - 2^A x CH*D entries, masked sync write, async read, async active-low clear.
- The top level contains the FSM, divider, index/direction logic and output register.

Test Plan:
- Reset: assert rst_n=0 mid-RUN -> out_valid=0, busy=0, done=0, out_data=0 immediately, without waiting for clk; a later read shows table entries =0.
- One-shot:
  - Write ch0 idx0..3 = 1000,0000,1000,2000 and ch1 = 0000,1000,1000,0000.
  - Run mode=0, len=3, rate=0, out_ready=1.
  - Expect out_addr 0,1,2,3 on consecutive cycles, out_data 0000_1000, 1000_0000, 1000_1000, 0000_2000 (ch1 in the upper lane).
  - Then done pulses once and busy falls on the same cycle.
- Loop: mode=1, len=2, rate=2 -> out_addr 0,1,2,0,1, spaced exactly 3 cycles apart; no done pulse.
- Ping-pong:
  - len=3 -> out_addr 0,1,2,3,2,1,0,1.
  - len=0 -> continuous index 0.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_addr stable; after release, the next index follows with no skip.
- Stop and write:
  - stop during a stall -> pending sample held until accepted, then IDLE with done=0.
  - start+stop in IDLE -> stays idle.
  - Masked write (wr_mask=01) to the index being emitted -> old value emitted, new ch0 value appears on the next pass, ch1 unchanged.
